rr_arbiter8: RTL and testbench



---
 rtl/rr_arbiter8.sv | 165 ++++++++++++++++
 tb/tb_rr_arbiter8.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter producing a registered one-hot grant for the downstream 8-to-3 encoder.
// Optional RR_ARB_CODE_EN macro adds a registered binary grant code output (gnt_code).
module rr_arbiter8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [7:0] gnt,
`ifdef RR_ARB_CODE_EN
    output logic [2:0] gnt_code,
`endif
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic       gnt_valid_q, gnt_valid_d;
`ifdef RR_ARB_CODE_EN
    logic [2:0] gnt_code_q, gnt_code_d;
`endif
    logic [2:0] winner_s;
    logic       release_s;

    // Circular search for the first set request bit, starting at the priority pointer.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] pick;
        logic [2:0] j;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            j = p + 3'(k);
            if (!found && r[j]) begin
                pick  = j;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Winner selection and grant release decode.
    always_comb begin
        winner_s  = rr_pick(req, ptr_q);
        release_s = ack | ~req[idx_q] | (hold_cnt_q == 8'(MAX_HOLD));
    end

    // State register and all datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            idx_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 8'h00;
            gnt_valid_q <= 1'b0;
`ifdef RR_ARB_CODE_EN
            gnt_code_q  <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
`ifdef RR_ARB_CODE_EN
            gnt_code_q  <= gnt_code_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req != 8'h00) begin
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = GRANT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; a release always passes through an all-zero cycle.
    always_comb begin
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
`ifdef RR_ARB_CODE_EN
        gnt_code_d  = gnt_code_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != 8'h00) begin
                    idx_d       = winner_s;
                    hold_cnt_d  = 8'd1;
                    gnt_d       = 8'b0000_0001 << winner_s;
                    gnt_valid_d = 1'b1;
`ifdef RR_ARB_CODE_EN
                    gnt_code_d  = winner_s;
`endif
                end else begin
                    hold_cnt_d  = 8'd0;
                    gnt_d       = 8'h00;
                    gnt_valid_d = 1'b0;
`ifdef RR_ARB_CODE_EN
                    gnt_code_d  = 3'd0;
`endif
                end
            end
            GRANT: begin
                if (release_s) begin
                    ptr_d       = idx_q + 3'd1;
                    hold_cnt_d  = 8'd0;
                    gnt_d       = 8'h00;
                    gnt_valid_d = 1'b0;
`ifdef RR_ARB_CODE_EN
                    gnt_code_d  = 3'd0;
`endif
                end else begin
                    hold_cnt_d  = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                hold_cnt_d  = 8'd0;
                gnt_d       = 8'h00;
                gnt_valid_d = 1'b0;
`ifdef RR_ARB_CODE_EN
                gnt_code_d  = 3'd0;
`endif
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
`ifdef RR_ARB_CODE_EN
    assign gnt_code  = gnt_code_q;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized and directed bench for rr_arbiter8 against a round-robin reference model.
module tb_rr_arbiter8;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic       gnt_valid;
`ifdef RR_ARB_CODE_EN
    logic [2:0] gnt_code;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who holds the grant, how long, and where the search starts next.
    bit         m_busy;
    int         m_cur, m_ptr, m_len;
    logic [7:0] prev_gnt;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .gnt       (gnt),
`ifdef RR_ARB_CODE_EN
        .gnt_code  (gnt_code),
`endif
        .gnt_valid (gnt_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_gnt();
        return m_busy ? 8'(1 << m_cur) : 8'h00;
    endfunction

    task automatic model_reset();
        m_busy   = 1'b0;
        m_cur    = 0;
        m_ptr    = 0;
        m_len    = 0;
        prev_gnt = 8'h00;
    endtask

    task automatic model_edge();
        if (!m_busy) begin
            if (req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (!m_busy && req[(m_ptr + k) % 8]) begin
                        m_cur  = (m_ptr + k) % 8;
                        m_busy = 1'b1;
                        m_len  = 1;
                    end
                end
            end
        end else if (ack || !req[m_cur] || m_len == MH) begin
            m_busy = 1'b0;
            m_ptr  = (m_cur + 1) % 8;
        end else begin
            m_len++;
        end
    endtask

    task automatic check_outputs();
        check_eq("gnt", gnt, m_gnt());
        check_eq("gnt_valid", gnt_valid, m_busy);
`ifdef RR_ARB_CODE_EN
        check_eq("gnt_code", gnt_code, m_busy ? m_cur : 0);
`endif
        if (prev_gnt != 8'h00 && gnt != 8'h00) check_eq("no_direct_switch", gnt, prev_gnt);
        prev_gnt = gnt;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        ack = 1'b0;
        #1;
        model_reset();
        check_eq("rst_gnt", gnt, 8'h00);
        check_eq("rst_valid", gnt_valid, 1'b0);
`ifdef RR_ARB_CODE_EN
        check_eq("rst_code", gnt_code, 3'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] last;
        logic [7:0] seen[$];
        logic [7:0] exp_g;

        // Reset and idle
        do_reset();
        for (int i = 0; i < 10; i++) cycle();

        // Single requester with ack in the 3rd grant cycle; next grant proves ptr=4
        req = 8'h08;
        cycle();
        check_eq("req08_grant", gnt, 8'h08);
        cycle();
        cycle();
        ack = 1'b1;
        cycle();
        check_eq("ack_release", gnt, 8'h00);
        ack = 1'b0;
        req = 8'hFF;
        cycle();
        check_eq("ptr_at_4", gnt, 8'h10);
        cycle();
        do_reset();
        check_eq("mid_grant_reset_model", m_gnt(), 8'h00);

        // All requesting, ack every 2nd grant cycle: rotating order with wrap
        req  = 8'hFF;
        last = 8'h00;
        for (int i = 0; i < 30; i++) begin
            ack = (m_busy && m_len == 2);
            cycle();
            if (gnt != 8'h00 && last == 8'h00) seen.push_back(gnt);
            last = gnt;
        end
        ack = 1'b0;
        check_eq("rotation_count", seen.size() >= 9, 1'b1);
        for (int i = 0; i < 9 && i < seen.size(); i++) begin
            exp_g = 8'(1 << (i % 8));
            check_eq("rotation_order", seen[i], exp_g);
        end

        // req=81 with no ack: hold limit forces alternation
        do_reset();
        req = 8'h81;
        for (int i = 0; i < 15; i++) begin
            cycle();
            exp_g = (i % 5 == 4) ? 8'h00 : (((i / 5) % 2 == 0) ? 8'h01 : 8'h80);
            check_eq("hold_limit_trace", gnt, exp_g);
        end

        // Grantee drops its request while others wiggle
        do_reset();
        req = 8'hFF;
        cycle();
        check_eq("drop_first", gnt, 8'h01);
        for (int i = 0; i < 2; i++) begin
            req = 8'($urandom) | 8'h01;
            cycle();
            check_eq("others_ignored", gnt, 8'h01);
        end
        req = (8'($urandom) & 8'hFE) | 8'h02;
        cycle();
        check_eq("drop_release", gnt, 8'h00);
        cycle();

`ifdef RR_ARB_CODE_EN
        do_reset();
        req = 8'h20;
        cycle();
        check_eq("code_gnt20", gnt, 8'h20);
        check_eq("code_5", gnt_code, 3'd5);
`endif

        // Random traffic with occasional asynchronous reset
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 60) == 0) do_reset();
            else cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
